pitch_period_engine: RTL and testbench
======================================

PITCH_PERIOD_ENGINE -- requirements
Module: pitch_period_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent pitch channels.
REQ-002 SHALL have parameter PITCH_W, default 10: pitch width; upper PITCH_W-8 bits are octave, lower 8 bits are fraction.
REQ-003 SHALL have parameter PERIOD_W, default 14: output period width in cycles/sample.
REQ-004 SHALL have parameter BASE_PERIOD, default 9088: period at pitch 0.
REQ-005 SHALL have parameter GLIDE_STEP, default 64: maximum period change per pass when glide is compiled in.
REQ-006 SHALL have port clk, input, 1: single system clock, all logic rising-edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: one-cycle request to convert all channels.
REQ-009 SHALL have port pitch, input, NUM_CH x PITCH_W: per-channel pitch, snapshotted on accepted start.
REQ-010 SHALL have port busy, output, 1: conversion pass in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at end of pass.
REQ-012 SHALL have port sample_period, output, NUM_CH x PERIOD_W: registered per-channel period.

Function
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored and not queued.
REQ-014 SHALL snapshot all pitch channels on the accepted start edge; later pitch changes SHALL NOT affect the pass.
REQ-015 SHALL implement FSM IDLE -> RUN (issue one channel per cycle, channel 0 first) -> DRAIN (empty pipeline) -> IDLE.
REQ-016 SHALL compute per channel, frac = pitch[7:0], oct = pitch >> 8: t1 = frac*(BASE_PERIOD/2); t2 = |((pitch+128) mod 256) - 128| * 826; t3 = |((pitch+64) mod 128) - 64| * 367; target = (BASE_PERIOD - ((t1+t2+t3) >> 8)) >> oct.
REQ-017 SHALL size intermediate products and sums so no overflow occurs for any PITCH_W-bit pitch (at least 21 bits for defaults).
REQ-018 SHALL use a 3-stage pipeline (products; sum and subtract; shift and write) so sample_period[c] updates on the edge c+3 cycles after the start edge.
REQ-019 SHALL raise busy on the edge after accepted start and drop it on the edge done is asserted.
REQ-020 SHALL assert done for exactly one cycle on the edge the last channel (NUM_CH-1) updates.
REQ-021 SHALL hold every sample_period value constant between its own update edges.
REQ-022 SHALL accept start in the cycle immediately after done, giving back-to-back passes.

Reset
REQ-023 SHALL, on rst asserted, asynchronously force state IDLE, busy=0, done=0, every sample_period=BASE_PERIOD, and clear the pipeline.
REQ-024 SHALL, on rst mid-pass, abandon the pass with no done pulse, and SHALL ignore start while rst is high.

Configuration
REQ-025 SHALL, when PITCH_PERIOD_GLIDE_EN is defined, write sample_period[c] moved toward target by at most GLIDE_STEP per pass, landing exactly on target when within GLIDE_STEP.
REQ-026 SHALL, when PITCH_PERIOD_GLIDE_EN is undefined, write target directly, and GLIDE_STEP SHALL be unused.

Structure
REQ-027 SHALL place the FSM state enum, the constants 826 and 367, and the fraction width 8 in shared package pitch_period_pkg.
REQ-028 SHALL instantiate the per-channel arithmetic as sub-module pitch_period_lerp (pipelined, with valid and channel index carried alongside data); the FSM, snapshot and output registers SHALL stay in the top module.

Verification
REQ-029 SHALL cover: defaults, no glide, pitch = {0, 128, 512, 1023}, start -> sample_period = {9088, 6403, 2272, 569}, with ch0 at start+3, ch3 at start+6, and done at start+6.
REQ-030 SHALL cover: start re-pulsed while busy -> ignored, exactly one done, outputs match first snapshot.
REQ-031 SHALL cover: pitch changed one cycle after start -> outputs reflect the pre-change values.
REQ-032 SHALL cover: rst asserted at start+4 -> immediately busy=0, all outputs 9088, no done pulse.
REQ-033 SHALL cover: GLIDE_EN, GLIDE_STEP=1024, ch0 pitch 0 -> 256 -> passes yield 8064, 7040, 6016, 4992, 4544, then stable.
REQ-034 SHALL cover: an exhaustive sweep of pitch 0..1023 on ch0, compared against a reference model of REQ-016, and checked for no overflow and monotonic non-increasing output.

Source files
------------

// File: rtl/pitch_period_pkg.sv
// Shared constants, FSM encoding and fold helpers for the pitch-to-period converter.
package pitch_period_pkg;

   localparam int FRAC_W = 8;
   localparam int K_T2   = 826;
   localparam int K_T3   = 367;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   // Distance of the fraction from the nearest multiple of 256 (0..128).
   function automatic logic [7:0] fold_half(input logic [7:0] frac);
      return frac[7] ? 8'(9'd256 - {1'b0, frac}) : frac;
   endfunction

   // Distance of the low 7 fraction bits from the nearest multiple of 128 (0..64).
   function automatic logic [6:0] fold_quarter(input logic [6:0] f);
      return f[6] ? 7'(8'd128 - {1'b0, f}) : f;
   endfunction

endpackage

// File: rtl/pitch_period_lerp.sv
// Per-channel pitch-to-period arithmetic: products, then sum/subtract, then a
// combinational octave shift that the caller registers as its write stage.
module pitch_period_lerp
   import pitch_period_pkg::*;
#(
   parameter int PITCH_W     = 10,
   parameter int PERIOD_W    = 14,
   parameter int BASE_PERIOD = 9088,
   parameter int CH_W        = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [CH_W-1:0]     in_ch,
   input  logic [PITCH_W-1:0]  in_pitch,
   output logic                out_valid,
   output logic [CH_W-1:0]     out_ch,
   output logic [PERIOD_W-1:0] out_period
);

   localparam int OCT_W  = PITCH_W - FRAC_W;
   localparam int PROD_W = PERIOD_W + FRAC_W + 2;
   localparam logic [PROD_W-1:0] BASE_P = PROD_W'(BASE_PERIOD);

   logic [FRAC_W-1:0]   frac;
   logic                v1_q, v1_d, v2_q, v2_d;
   logic [CH_W-1:0]     ch1_q, ch1_d, ch2_q, ch2_d;
   logic [OCT_W-1:0]    oct1_q, oct1_d, oct2_q, oct2_d;
   logic [PROD_W-1:0]   t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
   logic [PROD_W-1:0]   sum, quot;
   logic [PERIOD_W-1:0] diff_q, diff_d;

   always_comb begin
      frac   = in_pitch[FRAC_W-1:0];
      v1_d   = in_valid;
      ch1_d  = in_ch;
      oct1_d = in_pitch[PITCH_W-1:FRAC_W];
      t1_d   = PROD_W'(frac) * PROD_W'(BASE_PERIOD / 2);
      t2_d   = PROD_W'(fold_half(frac)) * PROD_W'(K_T2);
      t3_d   = PROD_W'(fold_quarter(frac[6:0])) * PROD_W'(K_T3);
   end

   // Saturate at zero so a non-default base/width combination cannot wrap.
   always_comb begin
      sum    = t1_q + t2_q + t3_q;
      quot   = sum >> FRAC_W;
      v2_d   = v1_q;
      ch2_d  = ch1_q;
      oct2_d = oct1_q;
      diff_d = (quot > BASE_P) ? '0 : PERIOD_W'(BASE_P - quot);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         ch1_q  <= '0;
         ch2_q  <= '0;
         oct1_q <= '0;
         oct2_q <= '0;
         t1_q   <= '0;
         t2_q   <= '0;
         t3_q   <= '0;
         diff_q <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         ch1_q  <= ch1_d;
         ch2_q  <= ch2_d;
         oct1_q <= oct1_d;
         oct2_q <= oct2_d;
         t1_q   <= t1_d;
         t2_q   <= t2_d;
         t3_q   <= t3_d;
         diff_q <= diff_d;
      end
   end

   assign out_valid  = v2_q;
   assign out_ch     = ch2_q;
   assign out_period = diff_q >> oct2_q;

endmodule

// File: rtl/pitch_period_engine.sv
// Multi-channel pitch-to-sample-period engine: snapshot, sequence, register outputs.
// Define PITCH_PERIOD_GLIDE_EN to slew each output toward its target by GLIDE_STEP per pass.
module pitch_period_engine
   import pitch_period_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int PITCH_W     = 10,
   parameter int PERIOD_W    = 14,
   parameter int BASE_PERIOD = 9088,
   parameter int GLIDE_STEP  = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [NUM_CH-1:0][PITCH_W-1:0]    pitch,
   output logic                              busy,
   output logic                              done,
   output logic [NUM_CH-1:0][PERIOD_W-1:0]   sample_period
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   if (GLIDE_STEP < 1 || GLIDE_STEP >= (1 << PERIOD_W)) begin : g_bad_glide_step
      $error("GLIDE_STEP must lie in 1 .. 2**PERIOD_W-1");
   end

   state_t                          state_q, state_d;
   logic [CH_W-1:0]                 cnt_q, cnt_d;
   logic [NUM_CH-1:0][PITCH_W-1:0]  snap_q, snap_d;
   logic [NUM_CH-1:0][PERIOD_W-1:0] period_q, period_d;
   logic                            done_q, done_d;
   logic                            issue_valid;
   logic                            out_valid;
   logic [CH_W-1:0]                 out_ch;
   logic [PERIOD_W-1:0]             out_period, wr_period;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      snap_d      = snap_q;
      issue_valid = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            snap_d  = pitch;
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            issue_valid = 1'b1;
            if (cnt_q == LAST_CH) state_d = ST_DRAIN;
            else                  cnt_d   = CH_W'(cnt_q + 1'b1);
         end
         ST_DRAIN: if (out_valid && out_ch == LAST_CH) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   pitch_period_lerp #(
      .PITCH_W     (PITCH_W),
      .PERIOD_W    (PERIOD_W),
      .BASE_PERIOD (BASE_PERIOD),
      .CH_W        (CH_W)
   ) u_lerp (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (issue_valid),
      .in_ch      (cnt_q),
      .in_pitch   (snap_q[cnt_q]),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .out_period (out_period)
   );

`ifdef PITCH_PERIOD_GLIDE_EN
   logic [PERIOD_W:0] cur_x, tgt_x, step_x;
   always_comb begin
      cur_x  = {1'b0, period_q[out_ch]};
      tgt_x  = {1'b0, out_period};
      step_x = (PERIOD_W + 1)'(GLIDE_STEP);
      if (tgt_x > cur_x + step_x)      wr_period = PERIOD_W'(cur_x + step_x);
      else if (tgt_x + step_x < cur_x) wr_period = PERIOD_W'(cur_x - step_x);
      else                             wr_period = out_period;
   end
`else
   assign wr_period = out_period;
`endif

   always_comb begin
      period_d = period_q;
      done_d   = 1'b0;
      if (out_valid) begin
         period_d[out_ch] = wr_period;
         done_d           = (out_ch == LAST_CH);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         snap_q   <= '0;
         period_q <= {NUM_CH{PERIOD_W'(BASE_PERIOD)}};
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         snap_q   <= snap_d;
         period_q <= period_d;
         done_q   <= done_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign sample_period = period_q;

endmodule

// File: tb/tb_pitch_period_engine.sv
// Directed bench for pitch_period_engine; glide build selected by PITCH_PERIOD_GLIDE_EN.
module tb_pitch_period_engine;

   localparam int NUM_CH   = 4;
   localparam int PITCH_W  = 10;
   localparam int PERIOD_W = 14;
`ifdef PITCH_PERIOD_GLIDE_EN
   localparam int GSTEP = 1024;
`else
   localparam int GSTEP = 64;
`endif

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [NUM_CH-1:0][PITCH_W-1:0]  pitch;
   logic busy;
   logic done;
   logic [NUM_CH-1:0][PERIOD_W-1:0] sample_period;

   int vectors     = 0;
   int miscompares = 0;
   int dones       = 0;

   always #5 clk = ~clk;
   always @(negedge clk) if (done === 1'b1) dones++;

   pitch_period_engine #(
      .NUM_CH      (NUM_CH),
      .PITCH_W     (PITCH_W),
      .PERIOD_W    (PERIOD_W),
      .BASE_PERIOD (9088),
      .GLIDE_STEP  (GSTEP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .pitch         (pitch),
      .busy          (busy),
      .done          (done),
      .sample_period (sample_period)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bounded wait that leaves the bench in the cycle where done is high.
   task automatic wait_done(input string tag);
      for (int i = 0; i < 30 && done !== 1'b1; i++) tick();
      check(tag, done, 1);
   endtask

   task automatic run_pass(input logic [NUM_CH-1:0][PITCH_W-1:0] p);
      pitch = p;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("pass_done");
      tick();
      $display("pass pitch0=%0d period0=%0d", p[0], sample_period[0]);
   endtask

   // Reference: target = (BASE - ((t1+t2+t3) >> 8)) >> oct, written from the formula.
   function automatic int model(input int p);
      int frac = p % 256;
      int oct  = p / 256;
      int a    = ((p + 128) % 256) - 128;
      int b    = ((p + 64) % 128) - 64;
      int t;
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      t = frac * (9088 / 2) + a * 826 + b * 367;
      return (9088 - (t >> 8)) >> oct;
   endfunction

   int d0;
   int prev;
`ifdef PITCH_PERIOD_GLIDE_EN
   int glide_exp [6] = '{8064, 7040, 6016, 4992, 4544, 4544};
`endif

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      pitch = '0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      for (int c = 0; c < NUM_CH; c++) check("rst_period", sample_period[c], 9088);
      rst = 1'b0;
      tick();

`ifdef PITCH_PERIOD_GLIDE_EN
      run_pass('0);
      check("glide_base", sample_period[0], 9088);
      for (int i = 0; i < 6; i++) begin
         run_pass({10'd0, 10'd0, 10'd0, 10'd256});
         check("glide_step", sample_period[0], glide_exp[i]);
         check("glide_other", sample_period[1], 9088);
      end
`else
      // Basic pass with latency checks
      d0    = dones;
      pitch = {10'd1023, 10'd512, 10'd128, 10'd0};
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_busy_rise", busy, 1);
      check("t1_done_low", done, 0);
      tick();
      tick();
      check("t1_ch1_pre", sample_period[1], 9088);
      tick();
      check("t1_ch0", sample_period[0], 9088);
      check("t1_ch1_hold", sample_period[1], 9088);
      tick();
      check("t1_ch1", sample_period[1], 6403);
      check("t1_ch2_pre", sample_period[2], 9088);
      tick();
      check("t1_ch2", sample_period[2], 2272);
      check("t1_ch3_pre", sample_period[3], 9088);
      check("t1_done_early", done, 0);
      check("t1_busy_mid", busy, 1);
      tick();
      check("t1_ch3", sample_period[3], 569);
      check("t1_done", done, 1);
      check("t1_busy_fall", busy, 0);
      tick();
      check("t1_done_pulse", done, 0);
      check("t1_done_count", dones - d0, 1);
      $display("step basic pass done");

      // Start re-pulsed while busy must be dropped
      d0    = dones;
      pitch = {10'd0, 10'd128, 10'd512, 10'd1023};
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      pitch = '0;
      for (int i = 0; i < 12; i++) tick();
      check("t2_one_done", dones - d0, 1);
      check("t2_idle", busy, 0);
      check("t2_ch0", sample_period[0], 569);
      check("t2_ch1", sample_period[1], 2272);
      check("t2_ch2", sample_period[2], 6403);
      check("t2_ch3", sample_period[3], 9088);
      $display("step restart-ignored done");

      // Snapshot isolation, then back-to-back start in the done cycle
      pitch = {10'd640, 10'd768, 10'd384, 10'd256};
      start = 1'b1;
      tick();
      start = 1'b0;
      pitch = '0;
      wait_done("t3_done");
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t3_b2b_busy", busy, 1);
      check("t3_ch0", sample_period[0], 4544);
      check("t3_ch1", sample_period[1], 3201);
      check("t3_ch2", sample_period[2], 1136);
      check("t3_ch3", sample_period[3], 1600);
      wait_done("t3_b2b_done");
      tick();
      for (int c = 0; c < NUM_CH; c++) check("t3_b2b_period", sample_period[c], 9088);
      $display("step snapshot/back-to-back done");

      // Reset in the middle of a pass
      pitch = {4{10'd512}};
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("t4_ch1_written", sample_period[1], 2272);
      d0  = dones;
      rst = 1'b1;
      #1;
      check("t4_busy", busy, 0);
      check("t4_done", done, 0);
      for (int c = 0; c < NUM_CH; c++) check("t4_period", sample_period[c], 9088);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      rst   = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("t4_no_done", dones - d0, 0);
      check("t4_still_idle", busy, 0);
      check("t4_ch0_reset", sample_period[0], 9088);
      $display("step mid-pass reset done");

      // Exhaustive sweep of channel 0
      prev = 9088;
      for (int p = 0; p < 1024; p++) begin
         logic [NUM_CH-1:0][PITCH_W-1:0] pv;
         pv    = '0;
         pv[0] = PITCH_W'(p);
         run_pass(pv);
         check("sweep_value", sample_period[0], model(p));
         check("sweep_mono", (int'(sample_period[0]) <= prev), 1);
         prev = int'(sample_period[0]);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
